// File: rtl/fn_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : fn_flags_if
// Description : Operand/result handshake bundle for fn_flags_pipe. The slave
//               modport is the pipeline's view; master is the producer/consumer
//               side that drives operands and accepts results.
// Revision    : 1.0 - initial release
// ============================================================================
interface fn_flags_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   funct3;
    logic         out_valid;
    logic         out_ready;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         taken;
    logic         illegal;

    modport slave (
        input  in_valid, a, b, funct3, out_ready,
        output in_ready, out_valid, zero, neg, carry, ovf, taken, illegal
    );

    modport master (
        output in_valid, a, b, funct3, out_ready,
        input  in_ready, out_valid, zero, neg, carry, ovf, taken, illegal
    );
endinterface
`default_nettype wire

// File: rtl/fn_flags_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fn_flags_pipe
// Description : Two-stage subtract-and-flag pipeline that evaluates the RV32I
//               branch condition selected by funct3. Stage 1 registers the
//               (W+1)-bit difference, stage 2 registers the flags and verdict.
//               Optional macro FLAGS_CNT_EN adds a saturating taken_cnt output
//               counting delivered taken results.
// Revision    : 1.0 - initial release
// ============================================================================
module fn_flags_pipe #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fn_flags_if.slave    bus
`ifdef FLAGS_CNT_EN
    ,
    output logic [CW-1:0] taken_cnt
`endif
);

    // Elaboration-time parameter range guards
    if (W < 8 || W > 64) begin : g_w_range_chk
        $error("fn_flags_pipe: W out of range 8..64");
    end
    if (CW < 4 || CW > 32) begin : g_cw_range_chk
        $error("fn_flags_pipe: CW out of range 4..32");
    end

    // Stage 1 state. Only the operand sign bits feed later logic (overflow),
    // so the rest of a/b is carried implicitly inside the difference.
    logic         r_s1_valid;
    logic [W:0]   r_diff;
    logic         r_a_msb;
    logic         r_b_msb;
    logic [2:0]   r_funct3;

    // Stage 2 state
    logic         r_s2_valid;
    logic         r_zero;
    logic         r_neg;
    logic         r_carry;
    logic         r_ovf;
    logic         r_taken;
    logic         r_illegal;

    logic         w_s2_adv;
    logic         w_in_ready;
    logic [W:0]   w_diff_in;
    logic         w_zero;
    logic         w_neg;
    logic         w_carry;
    logic         w_ovf;
    logic         w_taken;
    logic         w_illegal;

    // Each stage advances when empty or when the stage downstream drains, so
    // a full pipeline keeps streaming without a bubble.
    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;

    // Zero-extended subtract: bit W is the unsigned borrow.
    assign w_diff_in  = {1'b0, bus.a} - {1'b0, bus.b};

    assign w_zero  = (r_diff[W-1:0] == '0);
    assign w_neg   = r_diff[W-1];
    assign w_carry = r_diff[W];
    assign w_ovf   = (r_a_msb != r_b_msb) && (r_diff[W-1] != r_a_msb);

    // Branch verdict from funct3; codes 010/011 are not branches.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (r_funct3)
            3'b000:  w_taken = w_zero;
            3'b001:  w_taken = !w_zero;
            3'b100:  w_taken = w_neg ^ w_ovf;
            3'b101:  w_taken = !(w_neg ^ w_ovf);
            3'b110:  w_taken = w_carry;
            3'b111:  w_taken = !w_carry;
            default: w_illegal = 1'b1;
        endcase
    end

    // Stage 1: capture operands and difference on each input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_diff     <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_funct3   <= 3'b000;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_diff   <= w_diff_in;
                r_a_msb  <= bus.a[W-1];
                r_b_msb  <= bus.b[W-1];
                r_funct3 <= bus.funct3;
            end
        end
    end

    // Stage 2: register flags; result fields only change when a new result
    // moves in, so they hold their last value while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_zero    <= w_zero;
                r_neg     <= w_neg;
                r_carry   <= w_carry;
                r_ovf     <= w_ovf;
                r_taken   <= w_taken;
                r_illegal <= w_illegal;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.taken     = r_taken;
    assign bus.illegal   = r_illegal;

`ifdef FLAGS_CNT_EN
    localparam logic [CW-1:0] c_cnt_max = '1;

    logic [CW-1:0] r_taken_cnt;

    // Count delivered taken results, saturating rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt <= '0;
        end else if (r_s2_valid && bus.out_ready && r_taken && (r_taken_cnt != c_cnt_max)) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign taken_cnt = r_taken_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/fn_flags_pipe.md
FN_FLAGS_PIPE -- requirements
Module: fn_flags_pipe

Interface
REQ-001 Parameter W, default 32: operand width in bits; legal range 8..64.
REQ-002 Parameter CW, default 16: width of the taken-branch counter; legal range 4..32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand set a/b/funct3 presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  W  first operand (rs1).
REQ-008 b  input  W  second operand (rs2).
REQ-009 funct3  input  3  RV32I branch condition code.
REQ-010 out_valid  output  1  result fields hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 zero  output  1  (a-b) mod 2^W equals 0.
REQ-013 neg  output  1  bit W-1 of (a-b).
REQ-014 carry  output  1  borrow out of unsigned a-b (1 when a<b unsigned).
REQ-015 ovf  output  1  signed overflow of a-b.
REQ-016 taken  output  1  branch condition true for funct3.
REQ-017 illegal  output  1  funct3 is 010 or 011.
REQ-018 taken_cnt  output  CW  count of taken results delivered (present only with FLAGS_CNT_EN).

Function
REQ-019 The block SHALL be a 2-stage pipeline: S1 registers a, b, funct3 and the (W+1)-bit difference {1'b0,a}-{1'b0,b}; S2 registers all flags, taken and illegal.
REQ-020 Transfer on the input SHALL occur when in_valid && in_ready; on the output when out_valid && out_ready.
REQ-021 S2 advance: s2_adv = !s2_valid || out_ready; S1 advance: in_ready = !s1_valid || s2_adv (combinational, no bubble under continuous flow).
REQ-022 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput 1 result/cycle when out_ready stays high.
REQ-023 While out_valid && !out_ready, all S2 outputs SHALL hold stable; S1 SHALL hold if also full; no transaction lost or duplicated.
REQ-024 Flags: zero = diff[W-1:0]==0; neg = diff[W-1]; carry = diff[W]; ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
REQ-025 taken by funct3: 000 zero; 001 !zero; 100 neg^ovf; 101 !(neg^ovf); 110 carry; 111 !carry; 010/011 taken=0, illegal=1.
REQ-026 illegal SHALL be 0 for every legal funct3.
REQ-027 Result fields SHALL be held at their last value (not cleared) when out_valid is 0; consumers ignore them.

Reset
REQ-028 rst high SHALL immediately clear s1_valid, s2_valid, out_valid, all flags, taken, illegal and taken_cnt to 0, independent of clk.
REQ-029 Reset mid-operation SHALL discard all in-flight results; in_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-030 Macro FLAGS_CNT_EN defined: taken_cnt port exists and increments by 1 on each output transfer with taken=1, saturating at 2^CW-1 (no wrap).
REQ-031 FLAGS_CNT_EN undefined: taken_cnt port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 W=32, a=5, b=5, funct3=000, out_ready=1 -> 2 cycles later out_valid=1, zero=1, taken=1, carry=0, ovf=0.
REQ-033 a=0x80000000, b=1, funct3=100 -> ovf=1, neg=0, taken=1 (signed -2^31 < 1); same with funct3=110 -> carry=0, taken=0.
REQ-034 Back-to-back 4 transfers with out_ready low from cycle 2 -> in_ready drops after 2 accepted; results held stable; releasing out_ready delivers all 4 in order.
REQ-035 funct3=011, a=0, b=0 -> illegal=1, taken=0, zero=1.
REQ-036 rst asserted while 2 results in flight -> out_valid=0 asynchronously, nothing delivered afterwards, in_ready=1 after release.
REQ-037 FLAGS_CNT_EN, CW=4: 20 taken transfers -> taken_cnt=15 and held; untaken transfers leave it unchanged.
